// File: rtl/rah_sha_result_fifo.sv
// rah_sha_result_fifo: circular digest buffer between the SHA-256 core and the Rah/SHA bridge
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            synchronous clear of pointers and count
//   output_valid, hash1_out          digest strobe and digest from the SHA core
//   sha_done                         one-cycle acknowledge after every output_valid
//   sha_output_fifo_re               read request from the bridge
//   fifo_out_data                    registered read data, holds until the next accepted read
//   sha_fifo_empty, sha_fifo_full    status decoded from the registered count
//   fifo_count                       occupancy 0..DEPTH
//   overflow, underflow, clr_flags   sticky error flags and their clear
module rah_sha_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              output_valid,
   input  logic [DATA_W-1:0] hash1_out,
   output logic              sha_done,
   input  logic              sha_output_fifo_re,
   output logic              sha_fifo_empty,
   output logic [DATA_W-1:0] fifo_out_data,
   output logic              sha_fifo_full,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_flags
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wp, rp;
   logic [ADDR_W:0]   count;
   logic              wr_ok, rd_ok;
   assign fifo_count     = count;
   assign sha_fifo_empty = count == '0;
   assign sha_fifo_full  = count == (ADDR_W+1)'(DEPTH);
   assign rd_ok          = sha_output_fifo_re && !sha_fifo_empty;
   // a read frees a slot in the same edge, so a full FIFO still accepts a concurrent write
   assign wr_ok          = output_valid && (!sha_fifo_full || rd_ok);
   always_ff @(posedge clk)
      if (wr_ok && !flush) mem[wp] <= hash1_out;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp            <= '0;
         rp            <= '0;
         count         <= '0;
         fifo_out_data <= '0;
         sha_done      <= 1'b0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         sha_done <= output_valid;
         if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
         end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) begin
               rp            <= rp + 1'b1;
               fifo_out_data <= mem[rp];
            end
            count     <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
            // a new event in the same cycle beats clr_flags
            overflow  <= (output_valid && !wr_ok) || (overflow && !clr_flags);
            underflow <= (sha_output_fifo_re && sha_fifo_empty) || (underflow && !clr_flags);
         end
      end
endmodule

// File: tb/tb_rah_sha_result_fifo.sv
// tb_rah_sha_result_fifo: scoreboard bench for rah_sha_result_fifo against a queue-based model
module tb_rah_sha_result_fifo;
   localparam int DEPTH = 4;
   typedef struct {
      int         cnt;
      logic [255:0] data;
      logic       ovf, udf, done;
   } exp_t;
   logic         clk = 0, rst_n = 0, flush = 0, output_valid = 0, sha_output_fifo_re = 0, clr_flags = 0;
   logic [255:0] hash1_out = '0;
   logic         sha_done, sha_fifo_empty, sha_fifo_full, overflow, underflow;
   logic [255:0] fifo_out_data;
   logic [2:0]   fifo_count;
   int           n_vec = 0, n_err = 0;
   exp_t         exp_q[$];
   logic [255:0] m_q[$];
   logic [255:0] m_out = '0;
   logic         m_ovf = 0, m_udf = 0;
   rah_sha_result_fifo #(.DEPTH(DEPTH), .ADDR_W(2), .DATA_W(256)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .output_valid(output_valid), .hash1_out(hash1_out),
      .sha_done(sha_done), .sha_output_fifo_re(sha_output_fifo_re), .sha_fifo_empty(sha_fifo_empty),
      .fifo_out_data(fifo_out_data), .sha_fifo_full(sha_fifo_full), .fifo_count(fifo_count),
      .overflow(overflow), .underflow(underflow), .clr_flags(clr_flags));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   task automatic chk_all(input exp_t e);
      chk("count", 256'(fifo_count), 256'(e.cnt));
      chk("empty", 256'(sha_fifo_empty), 256'(e.cnt == 0));
      chk("full", 256'(sha_fifo_full), 256'(e.cnt == DEPTH));
      chk("data", fifo_out_data, e.data);
      chk("overflow", 256'(overflow), 256'(e.ovf));
      chk("underflow", 256'(underflow), 256'(e.udf));
      chk("sha_done", 256'(sha_done), 256'(e.done));
   endtask
   always @(negedge clk)
      if (exp_q.size() > 0) chk_all(exp_q.pop_front());
   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction
   // drive one cycle, advance the model by the same edge, queue the expected post-edge state
   task automatic cycle(input logic ov, input logic [255:0] d, input logic re, input logic fl, input logic cf);
      exp_t e;
      logic rd, wr, was_empty;
      output_valid = ov; hash1_out = d; sha_output_fifo_re = re; flush = fl; clr_flags = cf;
      was_empty = m_q.size() == 0;
      if (fl) m_q.delete();
      else begin
         rd = re && !was_empty;
         wr = ov && (m_q.size() < DEPTH || rd);
         if (rd) m_out = m_q.pop_front();
         if (wr) m_q.push_back(d);
         m_ovf = (ov && !wr) || (m_ovf && !cf);
         m_udf = (re && was_empty) || (m_udf && !cf);
      end
      e.cnt = m_q.size(); e.data = m_out; e.ovf = m_ovf; e.udf = m_udf; e.done = ov;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      output_valid = 0; sha_output_fifo_re = 0; flush = 0; clr_flags = 0;
   endtask
   task automatic async_reset();
      exp_t e;
      @(negedge clk); #1;
      rst_n = 0;
      m_q.delete(); m_out = '0; m_ovf = 0; m_udf = 0;
      e.cnt = 0; e.data = '0; e.ovf = 0; e.udf = 0; e.done = 0;
      #1 chk_all(e);
      @(posedge clk); #1;
      rst_n = 1;
   endtask
   initial begin
      logic [255:0] k, d[5];
      exp_t e0;
      k = {4{64'h0123456789ABCDEF}};
      for (int i = 0; i < 5; i++) d[i] = rnd256();
      #12;
      e0.cnt = 0; e0.data = '0; e0.ovf = 0; e0.udf = 0; e0.done = 0;
      chk_all(e0);
      @(posedge clk); #1 rst_n = 1;
      // single digest
      cycle(1, k, 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 0);
      // fill and overflow
      for (int i = 0; i < 5; i++) cycle(1, d[i], 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 1);
      // steady count of 2 across pointer wrap, then full with concurrent access
      cycle(1, rnd256(), 0, 0, 0);
      cycle(1, rnd256(), 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, rnd256(), 1, 0, 0);
      cycle(1, rnd256(), 0, 0, 0);
      cycle(1, rnd256(), 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(1, rnd256(), 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0);
      // write and read together while empty
      cycle(1, rnd256(), 1, 0, 0);
      cycle(0, '0, 0, 0, 1);
      cycle(0, '0, 1, 0, 0);
      // flush with a concurrent digest
      for (int i = 0; i < 2; i++) cycle(1, rnd256(), 0, 0, 0);
      cycle(1, rnd256(), 0, 1, 0);
      cycle(1, rnd256(), 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 0);
      // asynchronous reset with traffic in flight
      for (int i = 0; i < 3; i++) cycle(1, rnd256(), 0, 0, 0);
      async_reset();
      cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 99) < 55, rnd256(), $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8);
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
